sa_layer_receiver: RTL and testbench
====================================

Name: sa_layer_receiver

Overview:
Receiving end of the register-file layer-transfer interface. Captures one layer's layer info, weight tile and bias tile, which arrive in any order. Streams the weight tile row-by-row into the weight-stationary systolic array under a ready handshake, presents the masked bias and layer config, and then pulses received_SA_od back to the register file so it can advance the PC.

Parameters:
WIDTH, 8, tile columns
HEIGHT, 8, tile rows
DATA_WIDTH, 8, element width in bits

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
layer_info_iv  input  1  layer info valid strobe
weight_height_id  input  4  valid weight rows
weight_width_id  input  4  valid weight columns
bias_height_id  input  4  valid bias rows
bias_width_id  input  4  valid bias columns
op_id  input  3  {reLU_sel, op_sel, flatten}
is_first_layer  input  1  first-layer flag
is_final_layer  input  1  final-layer flag
weight_iv  input  1  weight tile valid strobe
weight_id  input  HEIGHT*WIDTH*DATA_WIDTH  packed [row][col][elem]
bias_iv  input  1  bias tile valid strobe
bias_id  input  HEIGHT*WIDTH*DATA_WIDTH  packed [row][col][elem]
sa_ready_i  input  1  systolic array accepts a row
sa_weight_ov  output  1  row valid
sa_weight_od  output  WIDTH*DATA_WIDTH  current masked row
sa_row_idx_od  output  $clog2(HEIGHT)  tile row index of sa_weight_od
sa_bias_od  output  HEIGHT*WIDTH*DATA_WIDTH  masked bias, held
sa_op_od  output  3  latched op
sa_final_od  output  1  latched is_final_layer
received_SA_od  output  1  one-cycle layer-loaded pulse
cfg_err_od  output  1  sticky, bad dimension
overrun_od  output  1  sticky, strobe while busy

Behaviour:
- Reset: all outputs 0, state IDLE, capture flags cleared, tile buffers 0. Reset mid-stream aborts the transfer immediately, with no received_SA_od pulse.
- States:
  - IDLE: no strobe captured yet.
  - COLLECT: at least one strobe captured.
  - STREAM: rows are being issued to the array.
  - DONE: one cycle.
- Capture, IDLE/COLLECT only:
  - Each strobe registers its data on the cycle it is high and sets its flag.
  - A repeated strobe overwrites the data; last write wins.
  - Simultaneous strobes are all captured.
  - A strobe in IDLE moves the FSM to COLLECT.
- COLLECT→STREAM: on the cycle after all three flags are set.
  - Latch sa_op_od and sa_final_od.
  - Drive sa_bias_od: element [r][c] passes if r<bias_height and c<bias_width, else 0.
- Dimension check: any height/width of 0 or >HEIGHT/WIDTH sets cfg_err_od. Transfer still proceeds, with the mask clamped to the tile size; 0 masks everything.
- STREAM:
  - 3-bit row counter cnt runs 0..HEIGHT-1. Emit tile row HEIGHT-1-cnt (bottom row first); sa_row_idx_od equals that row.
  - Row mask: elements with row>=weight_height or col>=weight_width are 0. All HEIGHT rows are always issued.
  - sa_weight_ov is registered and high throughout STREAM.
  - A row transfers on sa_weight_ov && sa_ready_i. Data holds stable while sa_ready_i=0.
  - After the last row (idx 0) transfers, go to DONE. Minimum latency from the final strobe to received_SA_od is HEIGHT+2 cycles.
- DONE:
  - received_SA_od=1 for exactly one cycle, sa_weight_ov=0, flags cleared, go to IDLE.
  - sa_bias_od, sa_op_od and sa_final_od hold until the next STREAM entry.
- A strobe during STREAM/DONE is ignored and sets overrun_od.
- Sticky bits clear only on rst.

Optional Feature:
SA_STALL_COUNT_EN:
- Defined:
  - Adds output stall_cnt_od (16 bits).
  - Counts cycles with sa_weight_ov=1 and sa_ready_i=0, saturating at 16'hFFFF.
  - Cleared on rst and on each COLLECT→STREAM entry.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Full tile, any-order arrival:
  - Stimulus: weight_iv, then bias_iv, then layer_info_iv, 8x8 dims, weight[r][c]=r*8+c, sa_ready_i=1.
  - Response: rows issued with idx 7..0 on 8 consecutive cycles; row 7 reads 0x38..0x3F.
  - received_SA_od pulses once, 10 cycles after layer_info_iv.
- Partial tile masking:
  - Stimulus: weight 3x5, bias 1x5, all data 8'hA7.
  - Response: rows 7..3 are all zero; rows 2..0 have cols 0-4 = A7 and cols 5-7 = 0.
  - sa_bias_od row 0 cols 0-4 = A7; everything else 0.
- Backpressure:
  - Stimulus: sa_ready_i low for 4 cycles while row 5 is presented.
  - Response: row 5 data stable for 5 cycles and no row skipped; stall_cnt_od=4 with SA_STALL_COUNT_EN defined.
- Overwrite and overrun:
  - Stimulus: two weight_iv in COLLECT (0x11 then 0x22); then weight_iv during STREAM.
  - Response: streamed data is 0x22; overrun_od=1; the stream is unaffected.
- Config error:
  - Stimulus: weight_height_id=0 or 9.
  - Response: cfg_err_od=1; 8 rows issued, clamped per the dimension-check rule; received_SA_od still pulses.
- Reset mid-stream:
  - Stimulus: rst asserted after 3 rows.
  - Response: next cycle all outputs 0, state IDLE, no received_SA_od pulse.
  - A new layer then completes normally.

Source files
------------

// File: rtl/sa_layer_receiver.sv
// rtl/sa_layer_receiver.sv - captures one layer (info, weight tile, bias tile) and streams masked weight rows into the systolic array
// Optional feature macro: SA_STALL_COUNT_EN adds stall_cnt_od, a saturating count of backpressured row cycles.
module sa_layer_receiver #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 layer_info_iv,
  input  logic [3:0]                           weight_height_id,
  input  logic [3:0]                           weight_width_id,
  input  logic [3:0]                           bias_height_id,
  input  logic [3:0]                           bias_width_id,
  input  logic [2:0]                           op_id,
  input  logic                                 is_first_layer,
  input  logic                                 is_final_layer,
  input  logic                                 weight_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   weight_id,
  input  logic                                 bias_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   bias_id,
  input  logic                                 sa_ready_i,
  output logic                                 sa_weight_ov,
  output logic [WIDTH*DATA_WIDTH-1:0]          sa_weight_od,
  output logic [$clog2(HEIGHT)-1:0]            sa_row_idx_od,
  output logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   sa_bias_od,
  output logic [2:0]                           sa_op_od,
  output logic                                 sa_final_od,
  output logic                                 received_SA_od,
  output logic                                 cfg_err_od,
`ifdef SA_STALL_COUNT_EN
  output logic [15:0]                          stall_cnt_od,
`endif
  output logic                                 overrun_od
);

  localparam int TW   = HEIGHT * WIDTH * DATA_WIDTH;
  localparam int RWID = WIDTH * DATA_WIDTH;
  localparam int IW   = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, COLLECT, STREAM, DONE} state_t;

  state_t            r_state;
  logic              r_have_info, r_have_w, r_have_b;
  logic [3:0]        r_w_h, r_w_w, r_b_h, r_b_w;
  logic [2:0]        r_op;
  logic              r_final;
  logic [TW-1:0]     r_weight, r_bias;
  logic [IW-1:0]     r_cnt, r_row_idx;
  logic              r_weight_ov;
  logic [RWID-1:0]   r_weight_row;
  logic [TW-1:0]     r_bias_out;
  logic [2:0]        r_op_out;
  logic              r_final_out, r_received, r_cfg_err, r_overrun;

  logic w_any_strobe, w_all_flags, w_dim_bad, w_unused;

  assign w_any_strobe = layer_info_iv | weight_iv | bias_iv;
  assign w_all_flags  = r_have_info & r_have_w & r_have_b;
  assign w_unused     = is_first_layer;

  function automatic logic f_dim_bad(input logic [3:0] d, input int lim);
    return (d == 4'd0) || (int'(d) > lim);
  endfunction

  // Oversized dimensions need no explicit clamp: every tile index is already below them.
  function automatic logic [RWID-1:0] f_row(input logic [TW-1:0] tile, input int row,
                                            input logic [3:0] h, input logic [3:0] w);
    logic [RWID-1:0] v;
    v = '0;
    for (int c = 0; c < WIDTH; c++)
      if (row < int'(h) && c < int'(w))
        v[c*DATA_WIDTH +: DATA_WIDTH] = tile[(row*WIDTH + c)*DATA_WIDTH +: DATA_WIDTH];
    return v;
  endfunction

  function automatic logic [TW-1:0] f_bias(input logic [TW-1:0] tile,
                                           input logic [3:0] h, input logic [3:0] w);
    logic [TW-1:0] v;
    v = '0;
    for (int r = 0; r < HEIGHT; r++)
      v[r*RWID +: RWID] = f_row(tile, r, h, w);
    return v;
  endfunction

  assign w_dim_bad = f_dim_bad(r_w_h, HEIGHT) | f_dim_bad(r_w_w, WIDTH) |
                     f_dim_bad(r_b_h, HEIGHT) | f_dim_bad(r_b_w, WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_have_info  <= 1'b0;
      r_have_w     <= 1'b0;
      r_have_b     <= 1'b0;
      r_w_h        <= '0;
      r_w_w        <= '0;
      r_b_h        <= '0;
      r_b_w        <= '0;
      r_op         <= '0;
      r_final      <= 1'b0;
      r_weight     <= '0;
      r_bias       <= '0;
      r_cnt        <= '0;
      r_row_idx    <= '0;
      r_weight_ov  <= 1'b0;
      r_weight_row <= '0;
      r_bias_out   <= '0;
      r_op_out     <= '0;
      r_final_out  <= 1'b0;
      r_received   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (layer_info_iv) begin
            r_have_info <= 1'b1;
            r_w_h       <= weight_height_id;
            r_w_w       <= weight_width_id;
            r_b_h       <= bias_height_id;
            r_b_w       <= bias_width_id;
            r_op        <= op_id;
            r_final     <= is_final_layer;
          end
          if (weight_iv) begin
            r_have_w <= 1'b1;
            r_weight <= weight_id;
          end
          if (bias_iv) begin
            r_have_b <= 1'b1;
            r_bias   <= bias_id;
          end
          if (r_state == IDLE) begin
            if (w_any_strobe) r_state <= COLLECT;
          end else if (w_all_flags) begin
            r_state      <= STREAM;
            r_cnt        <= '0;
            r_row_idx    <= IW'(HEIGHT - 1);
            r_weight_ov  <= 1'b1;
            r_weight_row <= f_row(r_weight, HEIGHT - 1, r_w_h, r_w_w);
            r_bias_out   <= f_bias(r_bias, r_b_h, r_b_w);
            r_op_out     <= r_op;
            r_final_out  <= r_final;
            if (w_dim_bad) r_cfg_err <= 1'b1;
          end
        end
        STREAM: begin
          if (sa_ready_i) begin
            if (r_cnt == IW'(HEIGHT - 1)) begin
              r_state      <= DONE;
              r_weight_ov  <= 1'b0;
              r_weight_row <= '0;
              r_row_idx    <= '0;
              r_received   <= 1'b1;
            end else begin
              r_cnt        <= r_cnt + 1'b1;
              r_row_idx    <= r_row_idx - 1'b1;
              r_weight_row <= f_row(r_weight, HEIGHT - 2 - int'(r_cnt), r_w_h, r_w_w);
            end
          end
        end
        DONE: begin
          r_received  <= 1'b0;
          r_have_info <= 1'b0;
          r_have_w    <= 1'b0;
          r_have_b    <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_any_strobe && (r_state == STREAM || r_state == DONE)) r_overrun <= 1'b1;
    end
  end

`ifdef SA_STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_state == COLLECT && w_all_flags)
      r_stall_cnt <= '0;
    else if (r_weight_ov && !sa_ready_i && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt_od = r_stall_cnt;
`endif

  assign sa_weight_ov   = r_weight_ov;
  assign sa_weight_od   = r_weight_row;
  assign sa_row_idx_od  = r_row_idx;
  assign sa_bias_od     = r_bias_out;
  assign sa_op_od       = r_op_out;
  assign sa_final_od    = r_final_out;
  assign received_SA_od = r_received;
  assign cfg_err_od     = r_cfg_err;
  assign overrun_od     = r_overrun;

endmodule

// File: tb/tb_sa_layer_receiver.sv
// tb/tb_sa_layer_receiver.sv - scoreboard bench for sa_layer_receiver
module tb_sa_layer_receiver;
  localparam int TW = 512;
  localparam int RW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          layer_info_iv = 1'b0, weight_iv = 1'b0, bias_iv = 1'b0, sa_ready_i = 1'b1;
  logic [3:0]    weight_height_id = '0, weight_width_id = '0, bias_height_id = '0, bias_width_id = '0;
  logic [2:0]    op_id = '0;
  logic          is_first_layer = 1'b0, is_final_layer = 1'b0;
  logic [TW-1:0] weight_id = '0, bias_id = '0;
  logic          sa_weight_ov, sa_final_od, received_SA_od, cfg_err_od, overrun_od;
  logic [RW-1:0] sa_weight_od;
  logic [2:0]    sa_row_idx_od, sa_op_od;
  logic [TW-1:0] sa_bias_od;
`ifdef SA_STALL_COUNT_EN
  logic [15:0]   stall_cnt_od;
`endif

  sa_layer_receiver dut (
    .clk(clk), .rst(rst), .layer_info_iv(layer_info_iv),
    .weight_height_id(weight_height_id), .weight_width_id(weight_width_id),
    .bias_height_id(bias_height_id), .bias_width_id(bias_width_id),
    .op_id(op_id), .is_first_layer(is_first_layer), .is_final_layer(is_final_layer),
    .weight_iv(weight_iv), .weight_id(weight_id), .bias_iv(bias_iv), .bias_id(bias_id),
    .sa_ready_i(sa_ready_i), .sa_weight_ov(sa_weight_ov), .sa_weight_od(sa_weight_od),
    .sa_row_idx_od(sa_row_idx_od), .sa_bias_od(sa_bias_od), .sa_op_od(sa_op_od),
    .sa_final_od(sa_final_od), .received_SA_od(received_SA_od), .cfg_err_od(cfg_err_od),
`ifdef SA_STALL_COUNT_EN
    .stall_cnt_od(stall_cnt_od),
`endif
    .overrun_od(overrun_od)
  );

  typedef struct {
    logic [2:0]    idx;
    logic [RW-1:0] data;
  } row_t;

  row_t sb[$];
  row_t mon_e;
  int checks = 0, errors = 0, cyc = 0;
  int rx_n = 0, xfer_n = 0, xfer_first = 0, xfer_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (received_SA_od === 1'b1) rx_n = rx_n + 1;
      if (sa_weight_ov === 1'b1 && sa_ready_i === 1'b1) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected_row got idx=%0d data=%h required no row", sa_row_idx_od, sa_weight_od);
        end else begin
          mon_e = sb.pop_front();
          if (sa_row_idx_od !== mon_e.idx || sa_weight_od !== mon_e.data) begin
            errors = errors + 1;
            $display("FAIL sb_row got idx=%0d data=%h required idx=%0d data=%h",
                     sa_row_idx_od, sa_weight_od, mon_e.idx, mon_e.data);
          end
        end
        if (xfer_n == 0) xfer_first = cyc;
        xfer_last = cyc;
        xfer_n = xfer_n + 1;
      end
    end
  end

  function automatic logic [RW-1:0] exp_row(input logic [TW-1:0] t, input int r, input int h, input int w);
    int hh = (h > 8) ? 8 : h;
    int ww = (w > 8) ? 8 : w;
    logic [RW-1:0] v = '0;
    for (int c = 0; c < 8; c++)
      if (r < hh && c < ww) v[c*8 +: 8] = t[(r*8 + c)*8 +: 8];
    return v;
  endfunction

  function automatic logic [TW-1:0] fill(input logic [7:0] b);
    logic [TW-1:0] v;
    for (int i = 0; i < 64; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rows(input logic [TW-1:0] t, input int h, input int w);
    for (int r = 7; r >= 0; r--) begin
      row_t e;
      e.idx  = 3'(r);
      e.data = exp_row(t, r, h, w);
      sb.push_back(e);
    end
  endtask

  task automatic set_dims(input int wh, input int ww, input int bh, input int bw,
                          input logic [2:0] op, input logic fin);
    weight_height_id = 4'(wh); weight_width_id = 4'(ww);
    bias_height_id = 4'(bh); bias_width_id = 4'(bw);
    op_id = op; is_final_layer = fin;
  endtask

  task automatic send_layer(input logic [TW-1:0] wd, input logic [TW-1:0] bd, input bit simul,
                            output int info_cyc);
    weight_id = wd; bias_id = bd;
    if (simul) begin
      weight_iv = 1'b1; bias_iv = 1'b1; layer_info_iv = 1'b1; info_cyc = cyc;
      tick();
      weight_iv = 1'b0; bias_iv = 1'b0; layer_info_iv = 1'b0;
    end else begin
      weight_iv = 1'b1; tick(); weight_iv = 1'b0;
      bias_iv = 1'b1; tick(); bias_iv = 1'b0;
      layer_info_iv = 1'b1; info_cyc = cyc; tick(); layer_info_iv = 1'b0;
    end
  endtask

  task automatic wait_rx(output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (received_SA_od === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks = checks + 3;
    if ({sa_weight_ov, received_SA_od, cfg_err_od, overrun_od, sa_final_od, sa_op_od, sa_row_idx_od} !== 11'd0) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl got %b required 0", {sa_weight_ov, received_SA_od, cfg_err_od, overrun_od, sa_final_od, sa_op_od, sa_row_idx_od});
    end
    if (sa_weight_od !== '0) begin errors = errors + 1; $display("FAIL reset_row got %h required 0", sa_weight_od); end
    if (sa_bias_od !== '0) begin errors = errors + 1; $display("FAIL reset_bias got %h required 0", sa_bias_od); end
    rst = 1'b0; tick();
  endtask

  task automatic test_full_order();
    logic [TW-1:0] w, b;
    int ic, at, rx0;
    bit ok;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) w[(r*8 + c)*8 +: 8] = 8'(r*8 + c);
    b = fill(8'h5A);
    push_rows(w, 8, 8);
    rx0 = rx_n; xfer_n = 0;
    set_dims(8, 8, 8, 8, 3'b101, 1'b1);
    send_layer(w, b, 1'b0, ic);
    wait_rx(ok, at);
    checks = checks + 6;
    if (!ok) begin errors = errors + 1; $display("FAIL full_rx_timeout got none required pulse"); end
    if (at - ic !== 10) begin errors = errors + 1; $display("FAIL full_latency got %0d required 10", at - ic); end
    if (xfer_n !== 8 || xfer_last - xfer_first !== 7) begin
      errors = errors + 1; $display("FAIL full_rows got n=%0d span=%0d required n=8 span=7", xfer_n, xfer_last - xfer_first);
    end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL full_sb_left got %0d required 0", sb.size()); end
    if (sa_bias_od !== b) begin errors = errors + 1; $display("FAIL full_bias got %h required %h", sa_bias_od, b); end
    if (sa_op_od !== 3'b101 || sa_final_od !== 1'b1) begin
      errors = errors + 1; $display("FAIL full_cfg got op=%b fin=%b required op=101 fin=1", sa_op_od, sa_final_od);
    end
    tick(); tick(); tick();
    checks = checks + 2;
    if (rx_n - rx0 !== 1) begin errors = errors + 1; $display("FAIL full_rx_count got %0d required 1", rx_n - rx0); end
    if (sa_weight_ov !== 1'b0 || sa_bias_od !== b) begin
      errors = errors + 1; $display("FAIL full_after got ov=%b bias_held=%b required ov=0 bias_held=1", sa_weight_ov, sa_bias_od === b);
    end
  endtask

  task automatic test_partial();
    logic [TW-1:0] t, eb;
    int ic, at;
    bit ok;
    t = fill(8'hA7);
    eb = '0; eb[39:0] = 40'hA7A7A7A7A7;
    push_rows(t, 3, 5);
    set_dims(3, 5, 1, 5, 3'b010, 1'b0);
    send_layer(t, t, 1'b1, ic);
    wait_rx(ok, at);
    checks = checks + 4;
    if (!ok) begin errors = errors + 1; $display("FAIL partial_rx_timeout got none required pulse"); end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL partial_sb_left got %0d required 0", sb.size()); end
    if (sa_bias_od !== eb) begin errors = errors + 1; $display("FAIL partial_bias got %h required %h", sa_bias_od, eb); end
    if (cfg_err_od !== 1'b0 || sa_op_od !== 3'b010 || sa_final_od !== 1'b0) begin
      errors = errors + 1; $display("FAIL partial_flags got err=%b op=%b fin=%b required 0 010 0", cfg_err_od, sa_op_od, sa_final_od);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] w;
    int ic, at, stable_n;
    bit ok, found;
    w = rand_tile();
    push_rows(w, 8, 8);
    xfer_n = 0; stable_n = 0; found = 1'b0;
    set_dims(8, 8, 8, 8, 3'b001, 1'b0);
    send_layer(w, rand_tile(), 1'b0, ic);
    for (int i = 0; i < 30; i++) begin
      if (sa_weight_ov === 1'b1 && sa_row_idx_od === 3'd5) begin found = 1'b1; break; end
      tick();
    end
    sa_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) sa_ready_i = 1'b1;
      @(negedge clk);
      if (sa_weight_ov === 1'b1 && sa_row_idx_od === 3'd5 && sa_weight_od === exp_row(w, 5, 8, 8)) stable_n++;
      tick();
    end
    wait_rx(ok, at);
    checks = checks + 4;
    if (!found) begin errors = errors + 1; $display("FAIL bp_row5_seen got 0 required 1"); end
    if (stable_n !== 5) begin errors = errors + 1; $display("FAIL bp_stable got %0d required 5", stable_n); end
    if (!ok || xfer_n !== 8) begin errors = errors + 1; $display("FAIL bp_done got rx=%b rows=%0d required rx=1 rows=8", ok, xfer_n); end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL bp_sb_left got %0d required 0", sb.size()); end
`ifdef SA_STALL_COUNT_EN
    checks = checks + 1;
    if (stall_cnt_od !== 16'd4) begin errors = errors + 1; $display("FAIL bp_stall_cnt got %0d required 4", stall_cnt_od); end
`endif
    tick();
  endtask

  task automatic test_overwrite_overrun();
    int at;
    bit ok, seen;
    checks = checks + 1;
    if (overrun_od !== 1'b0) begin errors = errors + 1; $display("FAIL ovr_initial got %b required 0", overrun_od); end
    push_rows(fill(8'h22), 8, 8);
    xfer_n = 0; seen = 1'b0;
    set_dims(8, 8, 8, 8, 3'b100, 1'b0);
    bias_id = fill(8'h01);
    weight_id = fill(8'h11); weight_iv = 1'b1; tick(); weight_iv = 1'b0; tick();
    weight_id = fill(8'h22); weight_iv = 1'b1; tick(); weight_iv = 1'b0;
    bias_iv = 1'b1; tick(); bias_iv = 1'b0;
    layer_info_iv = 1'b1; tick(); layer_info_iv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sa_weight_ov === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    weight_id = fill(8'h33); weight_iv = 1'b1; tick(); weight_iv = 1'b0;
    wait_rx(ok, at);
    checks = checks + 4;
    if (!seen) begin errors = errors + 1; $display("FAIL ovr_stream_seen got 0 required 1"); end
    if (overrun_od !== 1'b1) begin errors = errors + 1; $display("FAIL ovr_flag got %b required 1", overrun_od); end
    if (!ok || xfer_n !== 8) begin errors = errors + 1; $display("FAIL ovr_done got rx=%b rows=%0d required rx=1 rows=8", ok, xfer_n); end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL ovr_sb_left got %0d required 0", sb.size()); end
    tick();
  endtask

  task automatic test_cfg_err();
    logic [TW-1:0] w;
    int ic, at;
    bit ok;
    checks = checks + 1;
    if (cfg_err_od !== 1'b0) begin errors = errors + 1; $display("FAIL cfg_initial got %b required 0", cfg_err_od); end
    w = rand_tile();
    push_rows(w, 0, 8);
    set_dims(0, 8, 8, 8, 3'b000, 1'b0);
    send_layer(w, fill(8'h09), 1'b0, ic);
    wait_rx(ok, at);
    checks = checks + 3;
    if (!ok) begin errors = errors + 1; $display("FAIL cfg0_rx got none required pulse"); end
    if (cfg_err_od !== 1'b1) begin errors = errors + 1; $display("FAIL cfg0_flag got %b required 1", cfg_err_od); end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL cfg0_sb_left got %0d required 0", sb.size()); end
    tick();
    push_rows(w, 9, 8);
    set_dims(9, 8, 8, 8, 3'b000, 1'b0);
    send_layer(w, fill(8'h09), 1'b1, ic);
    wait_rx(ok, at);
    checks = checks + 2;
    if (!ok) begin errors = errors + 1; $display("FAIL cfg9_rx got none required pulse"); end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL cfg9_sb_left got %0d required 0", sb.size()); end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [TW-1:0] w;
    int ic, at, rx0;
    bit ok, found;
    w = rand_tile();
    push_rows(w, 8, 8);
    found = 1'b0;
    set_dims(8, 8, 8, 8, 3'b111, 1'b1);
    send_layer(w, rand_tile(), 1'b0, ic);
    for (int i = 0; i < 20; i++) begin
      if (sa_weight_ov === 1'b1 && sa_row_idx_od === 3'd4) begin found = 1'b1; break; end
      tick();
    end
    rst = 1'b1; tick();
    checks = checks + 3;
    if (!found) begin errors = errors + 1; $display("FAIL mid_row4_seen got 0 required 1"); end
    if ({sa_weight_ov, received_SA_od, cfg_err_od, overrun_od, sa_final_od, sa_op_od, sa_row_idx_od} !== 11'd0) begin
      errors = errors + 1;
      $display("FAIL mid_reset_ctrl got %b required 0", {sa_weight_ov, received_SA_od, cfg_err_od, overrun_od, sa_final_od, sa_op_od, sa_row_idx_od});
    end
    if (sa_weight_od !== '0 || sa_bias_od !== '0) begin
      errors = errors + 1; $display("FAIL mid_reset_data got row=%h required 0", sa_weight_od);
    end
    sb.delete();
    rst = 1'b0;
    rx0 = rx_n;
    for (int i = 0; i < 12; i++) tick();
    checks = checks + 1;
    if (rx_n !== rx0 || sa_weight_ov !== 1'b0) begin
      errors = errors + 1; $display("FAIL mid_no_pulse got rx=%0d ov=%b required rx=0 ov=0", rx_n - rx0, sa_weight_ov);
    end
    w = rand_tile();
    push_rows(w, 8, 8);
    xfer_n = 0;
    send_layer(w, rand_tile(), 1'b1, ic);
    wait_rx(ok, at);
    checks = checks + 2;
    if (!ok || xfer_n !== 8 || at - ic !== 10) begin
      errors = errors + 1; $display("FAIL mid_new_layer got rx=%b rows=%0d lat=%0d required 1 8 10", ok, xfer_n, at - ic);
    end
    if (sb.size() !== 0) begin errors = errors + 1; $display("FAIL mid_sb_left got %0d required 0", sb.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_order();
    test_partial();
    test_backpressure();
    test_overwrite_overrun();
    test_cfg_err();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
